// File: rtl/pipe_stall_if.sv
// ID-stage hazard inputs and stall-control outputs shared by the pipeline
// and the stall controller.
interface pipe_stall_if;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 3;

    logic             flush;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_rd_hi;
    logic             id_rd_lo;
    logic             id_is_div;
    logic             id_is_muldiv;
    logic             e_rf_wena;
    logic [REG_W-1:0] e_rf_waddr;
    logic             e_hi_wena;
    logic             e_lo_wena;
    logic             m_rf_wena;
    logic [REG_W-1:0] m_rf_waddr;
    logic             m_hi_wena;
    logic             m_lo_wena;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic             div_start;
    logic             div_busy;

    // Pipeline side: drives stage state, receives stall control
    modport master (
        output flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_rd_hi, id_rd_lo, id_is_div, id_is_muldiv,
               e_rf_wena, e_rf_waddr, e_hi_wena, e_lo_wena,
               m_rf_wena, m_rf_waddr, m_hi_wena, m_lo_wena,
        input  stall, bubble, stall_cnt, div_start, div_busy
    );

    // Controller side
    modport slave (
        input  flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_rd_hi, id_rd_lo, id_is_div, id_is_muldiv,
               e_rf_wena, e_rf_waddr, e_hi_wena, e_lo_wena,
               m_rf_wena, m_rf_waddr, m_hi_wena, m_lo_wena,
        output stall, bubble, stall_cnt, div_start, div_busy
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Count-based RAW interlock for the ID stage: detects GPR and HI/LO hazards
// against EXE/MEM writers and freezes PC/IF-ID for a fixed number of cycles
// while bubbling ID/EXE. Define MULDIV_STALL_EN to also track a multi-cycle
// divider and hold HI/LO/muldiv consumers until it finishes.
module pipe_stall_ctrl #(
    parameter int unsigned EXE_STALL  = 3,
    parameter int unsigned MEM_STALL  = 2,
    parameter int unsigned DIV_CYCLES = 32
) (
    input logic         clk,
    input logic         rst_n,
    pipe_stall_if.slave bus
);
    localparam int unsigned CNT_W = 3;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             haz_e;
    logic             haz_m;
    logic             haz_d;
    logic             stall_int;
    logic             div_start_int;
    logic             div_busy_int;

    // RAW hazards; register $0 is never a real dependency
    assign haz_e = (bus.id_valid & bus.e_rf_wena & (bus.e_rf_waddr != '0) &
                    ((bus.id_use_rs & (bus.id_rs == bus.e_rf_waddr)) |
                     (bus.id_use_rt & (bus.id_rt == bus.e_rf_waddr))))
                 | (bus.id_valid & ((bus.e_hi_wena & bus.id_rd_hi) |
                                    (bus.e_lo_wena & bus.id_rd_lo)));

    assign haz_m = (bus.id_valid & bus.m_rf_wena & (bus.m_rf_waddr != '0) &
                    ((bus.id_use_rs & (bus.id_rs == bus.m_rf_waddr)) |
                     (bus.id_use_rt & (bus.id_rt == bus.m_rf_waddr))))
                 | (bus.id_valid & ((bus.m_hi_wena & bus.id_rd_hi) |
                                    (bus.m_lo_wena & bus.id_rd_lo)));

    // The remaining-cycle counter is the FSM state: zero means RUN
    assign state = (cnt_q == '0) ? RUN : HOLD;

`ifdef MULDIV_STALL_EN
    localparam int unsigned DIV_W = 8;

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign div_busy_int  = (div_q != '0);
    assign haz_d         = div_busy_int & bus.id_valid &
                           (bus.id_rd_hi | bus.id_rd_lo | bus.id_is_muldiv);
    assign div_start_int = bus.id_valid & bus.id_is_div & ~stall_int & ~bus.flush;

    // Divider occupancy: load on issue, count down to idle; flush leaves it running
    always_comb begin
        div_d = div_q;
        if (div_start_int) begin
            div_d = DIV_W'(DIV_CYCLES);
        end else if (div_busy_int) begin
            div_d = div_q - DIV_W'(1);
        end
    end

    // Divider occupancy register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    logic unused_div;

    assign div_busy_int  = 1'b0;
    assign div_start_int = 1'b0;
    assign haz_d         = 1'b0;
    assign unused_div    = ^{bus.id_is_div, bus.id_is_muldiv, 8'(DIV_CYCLES)};
`endif

    // Next-state and stall decision; flush overrides everything
    always_comb begin
        cnt_d     = cnt_q;
        stall_int = 1'b0;
        if (bus.flush) begin
            cnt_d     = '0;
            stall_int = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    stall_int = haz_e | haz_m | haz_d;
                    if (haz_e) begin
                        cnt_d = CNT_W'(EXE_STALL - 1);
                    end else if (haz_m) begin
                        cnt_d = CNT_W'(MEM_STALL - 1);
                    end
                end
                HOLD: begin
                    stall_int = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end
                default: begin
                    cnt_d     = '0;
                    stall_int = 1'b0;
                end
            endcase
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Stall acts in the same cycle as the hazard; all control is quiet in reset
    assign bus.stall     = rst_n & stall_int;
    assign bus.bubble    = rst_n & stall_int;
    assign bus.stall_cnt = cnt_q;
    assign bus.div_start = rst_n & div_start_int;
    assign bus.div_busy  = rst_n & div_busy_int;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl (EXE_STALL=3, MEM_STALL=2, DIV_CYCLES=4).
// Hand-computed per-cycle expectations; divider checks follow MULDIV_STALL_EN.
module tb_pipe_stall_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipe_stall_if bus ();

    pipe_stall_ctrl #(
        .EXE_STALL (3),
        .MEM_STALL (2),
        .DIV_CYCLES(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic       rst_n;
        logic       rnd;
        logic       flush;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       rhi;
        logic       rlo;
        logic       isdiv;
        logic       ismd;
        logic       ewe;
        logic [4:0] ewa;
        logic       ehi;
        logic       elo;
        logic       mwe;
        logic [4:0] mwa;
        logic       mhi;
        logic       mlo;
        logic       xs;
        logic [2:0] xc;
        logic       xds;
        logic       xdb;
    } vec_t;

    typedef struct {
        logic       xs;
        logic [2:0] xc;
        logic       xds;
        logic       xdb;
        int         id;
    } ex_t;

    vec_t vecs[$];
    ex_t  ex_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t blank();
        vec_t v;
        v = '{default: '0};
        v.rst_n = 1'b1;
        v.valid = 1'b1;
        return v;
    endfunction

    function automatic vec_t rstv();
        vec_t v;
        v = blank();
        v.rst_n = 1'b0;
        v.rnd   = 1'b1;
        return v;
    endfunction

    function automatic vec_t gpr(logic fl, logic vl, logic [4:0] rs, logic urs,
                                 logic [4:0] rt, logic urt, logic ewe, logic [4:0] ewa,
                                 logic mwe, logic [4:0] mwa, logic xs, logic [2:0] xc);
        vec_t v;
        v = blank();
        v.flush = fl; v.valid = vl;
        v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt;
        v.ewe = ewe; v.ewa = ewa; v.mwe = mwe; v.mwa = mwa;
        v.xs = xs; v.xc = xc;
        return v;
    endfunction

    function automatic vec_t hilo(logic rhi, logic rlo, logic ehi, logic elo,
                                  logic mhi, logic mlo, logic xs, logic [2:0] xc);
        vec_t v;
        v = blank();
        v.rhi = rhi; v.rlo = rlo; v.ehi = ehi; v.elo = elo; v.mhi = mhi; v.mlo = mlo;
        v.xs = xs; v.xc = xc;
        return v;
    endfunction

    task automatic check(input string name, input int id, input logic [7:0] act,
                         input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec%0d: got %0h required %0h", name, id, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n = v.rst_n;
        if (v.rnd) begin
            bus.flush        = 1'($urandom);
            bus.id_valid     = 1'($urandom);
            bus.id_rs        = 5'($urandom);
            bus.id_rt        = 5'($urandom);
            bus.id_use_rs    = 1'($urandom);
            bus.id_use_rt    = 1'($urandom);
            bus.id_rd_hi     = 1'($urandom);
            bus.id_rd_lo     = 1'($urandom);
            bus.id_is_div    = 1'($urandom);
            bus.id_is_muldiv = 1'($urandom);
            bus.e_rf_wena    = 1'($urandom);
            bus.e_rf_waddr   = 5'($urandom);
            bus.e_hi_wena    = 1'($urandom);
            bus.e_lo_wena    = 1'($urandom);
            bus.m_rf_wena    = 1'($urandom);
            bus.m_rf_waddr   = 5'($urandom);
            bus.m_hi_wena    = 1'($urandom);
            bus.m_lo_wena    = 1'($urandom);
        end else begin
            bus.flush        = v.flush;
            bus.id_valid     = v.valid;
            bus.id_rs        = v.rs;
            bus.id_rt        = v.rt;
            bus.id_use_rs    = v.urs;
            bus.id_use_rt    = v.urt;
            bus.id_rd_hi     = v.rhi;
            bus.id_rd_lo     = v.rlo;
            bus.id_is_div    = v.isdiv;
            bus.id_is_muldiv = v.ismd;
            bus.e_rf_wena    = v.ewe;
            bus.e_rf_waddr   = v.ewa;
            bus.e_hi_wena    = v.ehi;
            bus.e_lo_wena    = v.elo;
            bus.m_rf_wena    = v.mwe;
            bus.m_rf_waddr   = v.mwa;
            bus.m_hi_wena    = v.mhi;
            bus.m_lo_wena    = v.mlo;
        end
    endtask

    // One cycle: drive at negedge, check same-cycle outputs, then the counter after the edge
    task automatic run_vec(input vec_t v, input int id);
        ex_t e;
        @(negedge clk);
        drive(v);
        ex_q.push_back('{v.xs, v.xc, v.xds, v.xdb, id});
        #1;
        e = ex_q[0];
        check("stall",     e.id, 8'(bus.stall),     8'(e.xs));
        check("bubble",    e.id, 8'(bus.bubble),    8'(e.xs));
        check("div_start", e.id, 8'(bus.div_start), 8'(e.xds));
        check("div_busy",  e.id, 8'(bus.div_busy),  8'(e.xdb));
        @(posedge clk);
        #1;
        e = ex_q.pop_front();
        check("stall_cnt", e.id, 8'(bus.stall_cnt), 8'(e.xc));
    endtask

    initial begin
        vec_t v;
        int   id;

        rst_n = 1'b0;
        drive(blank());
        rst_n = 1'b0;

        // reset with random inputs
        vecs.push_back(rstv());
        vecs.push_back(rstv());
        // EXE producer on rs: 3-cycle stall, counter 2,1,0; hazard held through HOLD
        vecs.push_back(gpr(0, 1, 8, 1, 0, 0, 1, 8, 0, 0, 1, 2));
        vecs.push_back(gpr(0, 1, 8, 1, 0, 0, 1, 8, 0, 0, 1, 1));
        vecs.push_back(gpr(0, 1, 8, 1, 0, 0, 1, 8, 0, 0, 1, 0));
        vecs.push_back(gpr(0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        // MEM producer on rt: 2-cycle stall
        vecs.push_back(gpr(0, 1, 0, 0, 9, 1, 0, 0, 1, 9, 1, 1));
        vecs.push_back(gpr(0, 1, 0, 0, 9, 1, 0, 0, 1, 9, 1, 0));
        vecs.push_back(gpr(0, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0));
        // $0 writers, invalid ID, unused sources, mismatched addresses: no stall
        vecs.push_back(gpr(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(gpr(0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(gpr(0, 0, 8, 1, 0, 0, 1, 8, 0, 0, 0, 0));
        vecs.push_back(gpr(0, 1, 8, 0, 8, 0, 1, 8, 1, 8, 0, 0));
        vecs.push_back(gpr(0, 1, 3, 1, 9, 1, 1, 8, 1, 7, 0, 0));
        // EXE and MEM together: EXE count wins; flush in the 2nd cycle clears
        vecs.push_back(gpr(0, 1, 8, 1, 9, 1, 1, 8, 1, 9, 1, 2));
        vecs.push_back(gpr(1, 1, 8, 1, 9, 1, 1, 8, 1, 9, 0, 0));
        vecs.push_back(gpr(0, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        // flush beats a fresh hazard in RUN
        vecs.push_back(gpr(1, 1, 8, 1, 0, 0, 1, 8, 0, 0, 0, 0));
        vecs.push_back(gpr(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // HI from EXE: 3 cycles; LO writer vs HI reader: none; LO from MEM: 2 cycles
        vecs.push_back(hilo(1, 0, 1, 0, 0, 0, 1, 2));
        vecs.push_back(hilo(1, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(hilo(1, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(hilo(0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(hilo(1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(hilo(0, 1, 0, 0, 0, 1, 1, 1));
        vecs.push_back(hilo(0, 1, 0, 0, 0, 1, 1, 0));
        vecs.push_back(hilo(0, 0, 0, 0, 0, 0, 0, 0));

        id = 0;
        foreach (vecs[i]) begin
            run_vec(vecs[i], id);
            id++;
        end

        // div issue, then mfhi waits for the divider; a flush mid-wait does not cancel it
        v = blank(); v.isdiv = 1'b1; v.ismd = 1'b1; v.rs = 5'd4; v.urs = 1'b1;
`ifdef MULDIV_STALL_EN
        v.xds = 1'b1;
`endif
        run_vec(v, id); id++;
        for (int c = 0; c < 5; c++) begin
            v = blank(); v.rhi = 1'b1;
            v.flush = (c == 2) ? 1'b1 : 1'b0;
`ifdef MULDIV_STALL_EN
            v.xdb = (c < 4) ? 1'b1 : 1'b0;
            v.xs  = (c < 4 && c != 2) ? 1'b1 : 1'b0;
`endif
            run_vec(v, id); id++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
